// File: rtl/keypad_emulator_if.sv
// Key request channel between a key source and the keypad emulator.
// A request transfers on a posedge with key_valid=1 and key_ready=1; key_code is only meaningful while key_valid=1.
interface keypad_emulator_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic       err;

   modport master (
      output key_valid,
      output key_code,
      input  key_ready,
      input  err
   );

   modport slave (
      input  key_valid,
      input  key_code,
      output key_ready,
      output err
   );
endinterface

// File: rtl/keypad_emulator.sv
// Scripted 4x3 keypad: plays back one requested key per handshake on the active-low column lines,
// aligned to scanner wraps, with optional contact bounce, a steady hold and a release gap.
module keypad_emulator #(
   parameter int unsigned BOUNCE_SCANS = 2,
   parameter int unsigned HOLD_SCANS   = 4,
   parameter int unsigned GAP_SCANS    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              sel,
   keypad_emulator_if.slave        kif,
   output logic [2:0]              column,
   output logic                    pressed,
   output logic [2:0]              o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC   = 3'd1,
      S_BOUNCE = 3'd2,
      S_HOLD   = 3'd3,
      S_GAP    = 3'd4
   } state_t;

   localparam logic [7:0] BOUNCE_LAST = 8'(BOUNCE_SCANS - 1);
   localparam logic [7:0] HOLD_LAST   = 8'(HOLD_SCANS - 1);
   localparam logic [7:0] GAP_LAST    = 8'(GAP_SCANS - 1);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [2:0] r_sel_q;
   logic [1:0] r_row;
   logic [2:0] r_col;
   logic       r_ready;
   logic       r_pressed;
   logic       r_err;

   logic       w_scan_evt;
   logic       w_key_ok;
   logic [1:0] w_row;
   logic [2:0] w_col;

   // One completed scan = the scanner wrapping straight from row 3 back to row 0.
   assign w_scan_evt = (r_sel_q == 3'b011) && (sel == 3'b000);

   always_comb begin
      w_key_ok = 1'b1;
      w_row    = 2'd0;
      w_col    = 3'b111;
      case (kif.key_code)
         4'd0: begin w_row = 2'd3; w_col = 3'b101; end
         4'd1: begin w_row = 2'd0; w_col = 3'b011; end
         4'd2: begin w_row = 2'd0; w_col = 3'b101; end
         4'd3: begin w_row = 2'd0; w_col = 3'b110; end
         4'd4: begin w_row = 2'd1; w_col = 3'b011; end
         4'd5: begin w_row = 2'd1; w_col = 3'b101; end
         4'd6: begin w_row = 2'd1; w_col = 3'b110; end
         4'd7: begin w_row = 2'd2; w_col = 3'b011; end
         4'd8: begin w_row = 2'd2; w_col = 3'b101; end
         4'd9: begin w_row = 2'd2; w_col = 3'b110; end
         default: w_key_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 8'd0;
         r_sel_q   <= 3'b111;
         r_row     <= 2'd0;
         r_col     <= 3'b111;
         r_ready   <= 1'b1;
         r_pressed <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_sel_q <= sel;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (kif.key_valid && r_ready) begin
                  if (w_key_ok) begin
                     r_row   <= w_row;
                     r_col   <= w_col;
                     r_ready <= 1'b0;
                     r_state <= S_SYNC;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_SYNC: begin
               if (w_scan_evt) begin
                  r_cnt     <= 8'd0;
                  r_pressed <= 1'b1;
                  r_state   <= (BOUNCE_SCANS == 0) ? S_HOLD : S_BOUNCE;
               end
            end
            S_BOUNCE: begin
               // Contact is closed on even bounce scans; the next scan index is even when r_cnt is odd.
               if (w_scan_evt) begin
                  if (r_cnt == BOUNCE_LAST) begin
                     r_cnt     <= 8'd0;
                     r_pressed <= 1'b1;
                     r_state   <= S_HOLD;
                  end else begin
                     r_cnt     <= r_cnt + 8'd1;
                     r_pressed <= r_cnt[0];
                  end
               end
            end
            S_HOLD: begin
               if (w_scan_evt) begin
                  if (r_cnt == HOLD_LAST) begin
                     r_cnt     <= 8'd0;
                     r_pressed <= 1'b0;
                     r_state   <= S_GAP;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
            end
            S_GAP: begin
               if (w_scan_evt) begin
                  if (r_cnt == GAP_LAST) begin
                     r_cnt   <= 8'd0;
                     r_ready <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
            end
            default: begin
               r_pressed <= 1'b0;
               r_ready   <= 1'b1;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   // Column follows sel combinationally so the scanner sees a settled value at its next sample.
   always_comb begin
      column = 3'b111;
      if (r_pressed && (sel == {1'b0, r_row})) column = r_col;
   end

   assign pressed       = r_pressed;
   assign kif.key_ready = r_ready;
   assign kif.err       = r_err;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (no bounce / three bounce scans) share one scanner sweep,
// each takes the same key request script, and both are checked against a scan-count reference model.
module tb_keypad_emulator;
   localparam int HOLD = 4;
   localparam int GAP  = 2;

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] sel = 3'b111;
   logic [1:0] kv;
   logic [3:0] kc [2];

   keypad_emulator_if kif0 ();
   keypad_emulator_if kif1 ();
   assign kif0.key_valid = kv[0];
   assign kif0.key_code  = kc[0];
   assign kif1.key_valid = kv[1];
   assign kif1.key_code  = kc[1];

   logic [2:0] col0, col1, st0, st1;
   logic       pr0, pr1;

   keypad_emulator #(.BOUNCE_SCANS(0), .HOLD_SCANS(HOLD), .GAP_SCANS(GAP)) dut0 (
      .clk(clk), .reset(reset), .sel(sel), .kif(kif0),
      .column(col0), .pressed(pr0), .o_dbg_state(st0)
   );
   keypad_emulator #(.BOUNCE_SCANS(3), .HOLD_SCANS(HOLD), .GAP_SCANS(GAP)) dut1 (
      .clk(clk), .reset(reset), .sel(sel), .kif(kif1),
      .column(col1), .pressed(pr1), .o_dbg_state(st1)
   );

   int total = 0;
   int bad   = 0;
   logic [5:0] exp_q[$];
   logic [3:0] req_q[$];
   int         gap_q[$];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: everything is derived from the number of completed scans
   int         nscan;
   logic [2:0] prev_sel;
   bit         busy [2];
   int         acc_scan [2];
   logic [1:0] m_row [2];
   logic [2:0] m_col [2];
   bit         m_ready [2];
   bit         m_err [2];
   bit         m_acc [2];
   bit         m_closed [2];
   bit         evt;

   function automatic int bn(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic logic [1:0] key_row(input logic [3:0] c);
      int v;
      v = int'(c);
      if (v == 0) return 2'd3;
      return 2'((v - 1) / 3);
   endfunction

   function automatic logic [2:0] key_col(input logic [3:0] c);
      int v, pos;
      v = int'(c);
      pos = (v == 0) ? 1 : (v - 1) % 3;
      return ~(3'b100 >> pos);
   endfunction

   function automatic bit contact(input int d);
      int k, b;
      if (!busy[d]) return 1'b0;
      k = nscan - acc_scan[d] - 1;
      b = bn(d);
      if (k < 0) return 1'b0;
      if (k < b) return (k % 2) == 0;
      return k < b + HOLD;
   endfunction

   function automatic bit in_hold(input int d);
      int k;
      k = nscan - acc_scan[d] - 1;
      return busy[d] && (k >= bn(d)) && (k < bn(d) + HOLD);
   endfunction

   function automatic logic [2:0] exp_col(input int d, input logic [2:0] s);
      if (m_closed[d] && (s == {1'b0, m_row[d]})) return m_col[d];
      return 3'b111;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         nscan = 0;
         prev_sel = 3'b111;
         for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; acc_scan[d] = 0; m_row[d] = 2'd0; m_col[d] = 3'b111;
            m_ready[d] = 1'b1; m_err[d] = 1'b0; m_acc[d] = 1'b0; m_closed[d] = 1'b0;
         end
      end else begin
         evt = (prev_sel == 3'b011) && (sel == 3'b000);
         prev_sel = sel;
         if (evt) nscan++;
         for (int d = 0; d < 2; d++) begin
            m_acc[d] = kv[d] && m_ready[d];
            m_err[d] = 1'b0;
            if (busy[d] && (nscan >= acc_scan[d] + bn(d) + HOLD + GAP + 1)) busy[d] = 1'b0;
            if (m_acc[d]) begin
               if (kc[d] <= 4'd9) begin
                  busy[d] = 1'b1;
                  acc_scan[d] = nscan;
                  m_row[d] = key_row(kc[d]);
                  m_col[d] = key_col(kc[d]);
               end else begin
                  m_err[d] = 1'b1;
               end
            end
            m_ready[d] = !busy[d];
            m_closed[d] = contact(d);
         end
      end
   end

   // monitor: per-cycle handshake/flag checks plus column samples from the scoreboard
   always @(negedge clk) begin
      logic [5:0] e;
      if (reset) begin
         chk("ready0", {7'd0, kif0.key_ready}, {7'd0, m_ready[0]});
         chk("ready1", {7'd0, kif1.key_ready}, {7'd0, m_ready[1]});
         chk("pressed0", {7'd0, pr0}, {7'd0, m_closed[0]});
         chk("pressed1", {7'd0, pr1}, {7'd0, m_closed[1]});
         chk("err0", {7'd0, kif0.err}, {7'd0, m_err[0]});
         chk("err1", {7'd0, kif1.err}, {7'd0, m_err[1]});
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("column0", {5'd0, col0}, {5'd0, e[2:0]});
            chk("column1", {5'd0, col1}, {5'd0, e[5:3]});
         end
      end
   end

   // request driver: keeps key_valid high until the model sees the handshake
   int rp [2];
   int wt [2];
   initial begin
      kv = 2'b00;
      kc[0] = 4'd0; kc[1] = 4'd0;
      rp[0] = 0; rp[1] = 0; wt[0] = 0; wt[1] = 0;
      forever begin
         @(posedge clk);
         #2;
         for (int d = 0; d < 2; d++) begin
            if (kv[d] && m_acc[d]) begin
               kv[d] = 1'b0;
               rp[d]++;
               if (rp[d] < req_q.size()) wt[d] = gap_q[rp[d]];
            end
            if (!kv[d] && reset && (rp[d] < req_q.size())) begin
               if (wt[d] > 0) wt[d]--;
               else begin
                  kv[d] = 1'b1;
                  kc[d] = req_q[rp[d]];
               end
            end
         end
      end
   end

   task automatic req(input logic [3:0] code, input int gap);
      req_q.push_back(code);
      gap_q.push_back(gap);
   endtask

   task automatic dwell(input logic [2:0] s);
      sel = s;
      repeat ($urandom_range(2, 4)) @(posedge clk);
      #1;
      exp_q.push_back({exp_col(1, s), exp_col(0, s)});
      @(negedge clk);
      #1;
   endtask

   task automatic sweep(input bit wrap);
      for (int r = 0; r < 4; r++) dwell(3'(r));
      if (!wrap) dwell(3'($urandom_range(4, 7)));
   endtask

   task automatic run_until_done(input int max_sweeps, input bit stalls);
      int n;
      n = 0;
      while (!((rp[0] == req_q.size()) && (rp[1] == req_q.size()) &&
               !busy[0] && !busy[1] && (kv == 2'b00))) begin
         if (n >= max_sweeps) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got %0d sweeps expected completion", n);
            return;
         end
         sweep(stalls ? ($urandom_range(0, 5) != 0) : 1'b1);
         n++;
      end
      sweep(1'b1);
   endtask

   initial begin
      bit found;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_column0", {5'd0, col0}, 8'b111);
      chk("rst_column1", {5'd0, col1}, 8'b111);
      chk("rst_ready0", {7'd0, kif0.key_ready}, 8'd1);
      chk("rst_pressed1", {7'd0, pr1}, 8'd0);
      @(negedge clk);
      #1;
      reset = 1'b1;

      repeat (3) sweep(1'b1);

      req(4'd5, 0);
      req(4'd0, 0);
      req(4'd12, 3);
      req(4'd7, 1);
      req(4'd3, 0);
      run_until_done(200, 1'b0);

      for (int i = 0; i < 14; i++) req(4'($urandom_range(0, 15)), $urandom_range(0, 8));
      run_until_done(400, 1'b1);

      req(4'd9, 0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         dwell(3'b000);
         if (in_hold(0) && in_hold(1)) begin
            dwell(3'b001);
            sel = 3'b010;
            @(posedge clk);
            #1;
            chk("hold9_column0", {5'd0, col0}, 8'b110);
            chk("hold9_column1", {5'd0, col1}, 8'b110);
            #3;
            reset = 1'b0;
            #1;
            chk("async_column0", {5'd0, col0}, 8'b111);
            chk("async_column1", {5'd0, col1}, 8'b111);
            chk("async_pressed0", {7'd0, pr0}, 8'd0);
            chk("async_state1", {5'd0, st1}, 8'd0);
            found = 1'b1;
         end else begin
            dwell(3'b001);
            dwell(3'b010);
            dwell(3'b011);
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL hold9_timeout: got no hold overlap expected one within 20 scans");
      end
      @(negedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_ready0", {7'd0, kif0.key_ready}, 8'd1);
      chk("post_rst_ready1", {7'd0, kif1.key_ready}, 8'd1);
      repeat (2) sweep(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
